ap_event_sync: RTL and testbench

Multi-channel synchronizer between HLS block-level handshake events (ap_done / ap_ready style) and testbench-side consumers. Each channel detects rising edges on its event line, queues them in a saturating pending counter, and answers consumer requests with a one-cycle sync pulse once an event is available. Optional per-channel event counters drive an aggregate completion flag. Sits in the SV testbench harness between the DUT control ports and the UVM sequencer/monitor layer.

---
 rtl/ap_event_sync_pkg.sv | 15 +
 rtl/ap_event_chan.sv | 114 +++++++++++
 rtl/ap_event_sync.sv | 66 ++++++
 tb/tb_ap_event_sync.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_event_sync_pkg.sv
// Shared state type and width helpers for the ap_event_sync channel logic.
// Optional counters are built when AP_EVENT_SYNC_CNT_EN is defined.
package ap_event_sync_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_e;

  // All-ones value for a field of width w, used to derive PEND_MAX / CNT_MAX.
  function automatic logic [63:0] all_ones(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/ap_event_chan.sv
// One event channel: rise detect, request FSM, saturating pending queue, sticky
// overflow and, with AP_EVENT_SYNC_CNT_EN defined, a saturating total-event counter.
module ap_event_chan
  import ap_event_sync_pkg::*;
#(
  parameter int PEND_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              chan_en,
  input  logic              evt,
  input  logic              req,
  output logic              req_busy,
  output logic              sync_pulse,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(all_ones(PEND_W));

  chan_state_e       state_q, state_d;
  logic              evt_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              sync_q, sync_d;
  logic              ovf_q, ovf_d;
  logic              rise, avail, grant, consume;

  always_comb begin
    rise    = evt & ~evt_q;
    // Grant decision looks only at the registered pending count.
    avail   = ~chan_en | (pend_q != '0);
    grant   = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (avail) grant = 1'b1;
          else       state_d = WAIT;
        end
      end
      WAIT: begin
        if (avail) begin
          grant   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    consume = grant & chan_en;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (rise && !consume) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!rise && consume) begin
      pend_d = pend_q - 1'b1;
    end
    sync_d = grant;

    if (clear) begin
      state_d = IDLE;
      pend_d  = '0;
      ovf_d   = 1'b0;
      sync_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      evt_q   <= 1'b0;
      state_q <= IDLE;
      pend_q  <= '0;
      sync_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      evt_q   <= evt;
      state_q <= state_d;
      pend_q  <= pend_d;
      sync_q  <= sync_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_busy   = (state_q == WAIT);
  assign sync_pulse = sync_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;

`ifdef AP_EVENT_SYNC_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(all_ones(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                          cnt_d = '0;
    else if (rise && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign evt_cnt = cnt_q;
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: rtl/ap_event_sync.sv
// Multi-channel HLS handshake event synchronizer; holds the all_done reduction,
// which (with the counters) exists only when AP_EVENT_SYNC_CNT_EN is defined.
module ap_event_sync #(
  parameter int NUM_CH = 2,
  parameter int PEND_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        chan_en,
  input  logic [NUM_CH-1:0]        evt,
  input  logic [NUM_CH-1:0]        req,
  input  logic [CNT_W-1:0]         target,
  output logic [NUM_CH-1:0]        req_busy,
  output logic [NUM_CH-1:0]        sync_pulse,
  output logic [NUM_CH*PEND_W-1:0] pending,
  output logic [NUM_CH*CNT_W-1:0]  evt_cnt,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     all_done
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ap_event_chan #(
      .PEND_W (PEND_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .chan_en    (chan_en[gi]),
      .evt        (evt[gi]),
      .req        (req[gi]),
      .req_busy   (req_busy[gi]),
      .sync_pulse (sync_pulse[gi]),
      .pending    (pending[gi*PEND_W +: PEND_W]),
      .evt_cnt    (evt_cnt[gi*CNT_W +: CNT_W]),
      .overflow   (overflow[gi])
    );
  end

`ifdef AP_EVENT_SYNC_CNT_EN
  logic all_done_q, all_done_d;

  // No enabled channel means nothing to wait for, which reads as "not done".
  always_comb begin
    all_done_d = |chan_en;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan_en[i] && (evt_cnt[i*CNT_W +: CNT_W] < target)) all_done_d = 1'b0;
    end
    if (clear) all_done_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) all_done_q <= 1'b0;
    else        all_done_q <= all_done_d;
  end

  assign all_done = all_done_q;
`else
  logic unused_target;
  assign unused_target = ^target;
  assign all_done      = 1'b0;
`endif

endmodule

// File: tb/tb_ap_event_sync.sv
// Self-checking bench for ap_event_sync: directed scenarios with literal expectations,
// then randomized traffic against a cycle-level behavioural model (AP_EVENT_SYNC_CNT_EN aware).
module tb_ap_event_sync;

  localparam int NUM_CH = 2;
  localparam int PEND_W = 2;
  localparam int CNT_W  = 8;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic                     clear = 1'b0;
  logic [NUM_CH-1:0]        chan_en = '0;
  logic [NUM_CH-1:0]        evt = '0;
  logic [NUM_CH-1:0]        req = '0;
  logic [CNT_W-1:0]         target = '0;
  logic [NUM_CH-1:0]        req_busy;
  logic [NUM_CH-1:0]        sync_pulse;
  logic [NUM_CH*PEND_W-1:0] pending;
  logic [NUM_CH*CNT_W-1:0]  evt_cnt;
  logic [NUM_CH-1:0]        overflow;
  logic                     all_done;

  ap_event_sync #(.NUM_CH(NUM_CH), .PEND_W(PEND_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .chan_en    (chan_en),
    .evt        (evt),
    .req        (req),
    .target     (target),
    .req_busy   (req_busy),
    .sync_pulse (sync_pulse),
    .pending    (pending),
    .evt_cnt    (evt_cnt),
    .overflow   (overflow),
    .all_done   (all_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", nm, ch, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pend_of(input int ch);
    return 32'(pending[ch*PEND_W +: PEND_W]);
  endfunction

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(evt_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  // Behavioural model: integer queue depth, an "outstanding request" flag, event totals.
  int  m_pend [NUM_CH];
  int  m_cnt  [NUM_CH];
  bit  m_wait [NUM_CH];
  bit  m_pulse[NUM_CH];
  bit  m_ovf  [NUM_CH];
  bit  m_prev [NUM_CH];
  bit  m_done = 1'b0;
  bit  m_live = 1'b0;

  always @(posedge clock) begin
    bit any_en, reached, rise, want, ok;
    int nxt;
    m_live = 1'b1;
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = 0; m_cnt[i] = 0; m_wait[i] = 0; m_pulse[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
      end
      m_done = 1'b0;
    end else begin
      any_en  = 1'b0;
      reached = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan_en[i]) begin
          any_en = 1'b1;
          if (m_cnt[i] < int'(target)) reached = 1'b0;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        rise = evt[i] && !m_prev[i];
        if (clear) begin
          m_pend[i] = 0; m_cnt[i] = 0; m_wait[i] = 0; m_pulse[i] = 0; m_ovf[i] = 0;
        end else begin
          want       = m_wait[i] || req[i];
          ok         = !chan_en[i] || (m_pend[i] > 0);
          m_pulse[i] = want && ok;
          m_wait[i]  = want && !ok;
          nxt = m_pend[i] + (rise ? 1 : 0) - ((m_pulse[i] && chan_en[i]) ? 1 : 0);
          if (nxt > PMAX) begin
            nxt      = PMAX;
            m_ovf[i] = 1'b1;
          end
          m_pend[i] = nxt;
          if (rise && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end
        m_prev[i] = evt[i];
      end
      m_done = !clear && any_en && reached;
    end
  end

  always @(posedge clock) begin
    #1;
    if (m_live) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chk("req_busy",   i, 32'(req_busy[i]),   32'(m_wait[i]));
        chk("sync_pulse", i, 32'(sync_pulse[i]), 32'(m_pulse[i]));
        chk("pending",    i, pend_of(i),         32'(m_pend[i]));
        chk("overflow",   i, 32'(overflow[i]),   32'(m_ovf[i]));
`ifdef AP_EVENT_SYNC_CNT_EN
        chk("evt_cnt",    i, cnt_of(i),          32'(m_cnt[i]));
`else
        chk("evt_cnt",    i, cnt_of(i),          32'd0);
`endif
      end
`ifdef AP_EVENT_SYNC_CNT_EN
      chk("all_done", 0, 32'(all_done), 32'(m_done));
`else
      chk("all_done", 0, 32'(all_done), 32'd0);
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    chan_en = 2'b11;
    cyc(3);
    chk("rst_pending",  0, 32'(pending),    32'd0);
    chk("rst_busy",     0, 32'(req_busy),   32'd0);
    chk("rst_pulse",    0, 32'(sync_pulse), 32'd0);
    chk("rst_overflow", 0, 32'(overflow),   32'd0);
    chk("rst_evt_cnt",  0, 32'(evt_cnt),    32'd0);
    chk("rst_all_done", 0, 32'(all_done),   32'd0);
    reset = 1'b1;
    cyc(2);

    // Request before event
    req = 2'b01; cyc();
    chk("t1_busy", 0, 32'(req_busy[0]), 32'd1);
    req = 2'b00; cyc(3);
    chk("t1_busy_hold", 0, 32'(req_busy[0]), 32'd1);
    evt[0] = 1'b1; cyc();
    chk("t1_pend_rise", 0, pend_of(0), 32'd1);
    chk("t1_no_pulse",  0, 32'(sync_pulse[0]), 32'd0);
    cyc();
    chk("t1_pulse",   0, 32'(sync_pulse[0]), 32'd1);
    chk("t1_busy_off", 0, 32'(req_busy[0]), 32'd0);
    chk("t1_pend0",   0, pend_of(0), 32'd0);
    evt[0] = 1'b0; cyc();
    chk("t1_pulse_once", 0, 32'(sync_pulse[0]), 32'd0);

    // Events before requests
    repeat (3) begin
      evt[0] = 1'b1; cyc();
      evt[0] = 1'b0; cyc();
    end
    chk("t2_pend3", 0, pend_of(0), 32'd3);
    for (int k = 2; k >= 0; k--) begin
      req = 2'b01; cyc();
      chk("t2_pulse", 0, 32'(sync_pulse[0]), 32'd1);
      chk("t2_pend",  0, pend_of(0), 32'(k));
      req = 2'b00; cyc();
      chk("t2_pulse_off", 0, 32'(sync_pulse[0]), 32'd0);
    end

    // Pending saturation
    repeat (5) begin
      evt[0] = 1'b1; cyc();
      evt[0] = 1'b0; cyc();
    end
    chk("t3_pend_sat", 0, pend_of(0), 32'd3);
    chk("t3_ovf",      0, 32'(overflow[0]), 32'd1);
    cyc(3);
    chk("t3_ovf_sticky", 0, 32'(overflow[0]), 32'd1);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("t3_ovf_clr",  0, 32'(overflow[0]), 32'd0);
    chk("t3_pend_clr", 0, pend_of(0), 32'd0);

    // Bypass grants, and disabling mid-WAIT
    chan_en = 2'b01;
    evt[1] = 1'b1; cyc();
    evt[1] = 1'b0; cyc();
    chk("t4_pend1", 1, pend_of(1), 32'd1);
    req = 2'b10; cyc();
    chk("t4_byp_pulse", 1, 32'(sync_pulse[1]), 32'd1);
    chk("t4_byp_pend",  1, pend_of(1), 32'd1);
    req = 2'b00; clear = 1'b1; cyc(); clear = 1'b0;
    chan_en = 2'b11; req = 2'b10; cyc();
    chk("t4_wait", 1, 32'(req_busy[1]), 32'd1);
    req = 2'b00; chan_en = 2'b01; cyc();
    chk("t4_dis_pulse", 1, 32'(sync_pulse[1]), 32'd1);
    chk("t4_dis_busy",  1, 32'(req_busy[1]), 32'd0);
    chan_en = 2'b11; cyc();

    // Simultaneous rise/consume and clear/rise
    evt[0] = 1'b1; cyc();
    evt[0] = 1'b0; cyc();
    evt[0] = 1'b1; req = 2'b01; cyc();
    chk("t5_pulse",     0, 32'(sync_pulse[0]), 32'd1);
    chk("t5_pend_same", 0, pend_of(0), 32'd1);
    evt[0] = 1'b0; req = 2'b00; cyc();
    evt[0] = 1'b1; clear = 1'b1; cyc();
    chk("t5_clr_pend", 0, pend_of(0), 32'd0);
    chk("t5_clr_cnt",  0, cnt_of(0),  32'd0);
    clear = 1'b0; evt[0] = 1'b0; cyc();
    chk("t5_clr_pend_after", 0, pend_of(0), 32'd0);

    // Event counters and all_done
    clear = 1'b1; cyc(); clear = 1'b0;
    target = 8'd4; chan_en = 2'b11;
    repeat (3) begin
      evt = 2'b11; cyc();
      evt = 2'b00; cyc();
    end
    evt = 2'b01; cyc();
    evt = 2'b00; cyc();
    chk("t6_done_pre", 0, 32'(all_done), 32'd0);
    evt = 2'b10; cyc();
`ifdef AP_EVENT_SYNC_CNT_EN
    chk("t6_cnt1", 1, cnt_of(1), 32'd4);
`endif
    chk("t6_done_lag", 0, 32'(all_done), 32'd0);
    evt = 2'b00; cyc();
`ifdef AP_EVENT_SYNC_CNT_EN
    chk("t6_done", 0, 32'(all_done), 32'd1);
`else
    chk("t6_done", 0, 32'(all_done), 32'd0);
`endif
    target = 8'd0; chan_en = 2'b00; cyc();
    chk("t6_done_noen", 0, 32'(all_done), 32'd0);
    chan_en = 2'b11; cyc();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 99) != 0);
      clear = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        chan_en[i] = ($urandom_range(0, 99) < 85);
        if ($urandom_range(0, 99) < 30) evt[i] = ~evt[i];
        req[i] = ($urandom_range(0, 99) < 25);
      end
      if (k % 200 == 0) target = CNT_W'($urandom_range(0, 10));
      cyc();
    end
    reset = 1'b1; clear = 1'b0; req = '0; evt = '0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
